// File: rtl/adc_avg_bcd.sv
// Block boxcar averager over 2^LOG2N ADC samples, followed by an iterative
// double-dabble converter that turns each completed average into 4-digit packed BCD.
module adc_avg_bcd #(
    parameter int DATA_W = 12,
    parameter int LOG2N  = 3
) (
    input  logic              SCLK,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic [15:0]       bcd_out,
    output logic              bcd_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int         ACC_W     = DATA_W + LOG2N;
    localparam logic [3:0] LAST_STEP = 4'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_next;

    logic [ACC_W-1:0]  acc;
    logic [LOG2N-1:0]  cnt;
    logic [ACC_W-1:0]  sum;
    logic              avg_done;
    logic [DATA_W-1:0] avg_new;

    logic [DATA_W-1:0] bin, bin_next, bin_sh;
    logic [15:0]       digits, digits_next, digits_sh, digits_adj;
    logic [3:0]        step, step_next;
    logic [15:0]       bcd_out_next;
    logic              bcd_valid_next;
    logic              overrun_next;

    // Sum includes the current sample so the final strobe produces the average on the same edge.
    assign sum      = acc + ACC_W'(data_in);
    assign avg_done = rx_done_tick && !clear && (cnt == '1);
    assign avg_new  = DATA_W'(sum >> LOG2N);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (rx_done_tick) begin
                if (avg_done) begin
                    avg_out   <= avg_new;
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + LOG2N'(1);
                end
            end
        end
    end

    function automatic logic [15:0] dabble_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign digits_adj = dabble_adjust(digits);
    assign digits_sh  = {digits_adj[14:0], bin[DATA_W-1]};
    assign bin_sh     = {bin[DATA_W-2:0], 1'b0};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next     = state;
        bin_next       = bin;
        digits_next    = digits;
        step_next      = step;
        bcd_out_next   = bcd_out;
        bcd_valid_next = 1'b0;
        overrun_next   = clear ? 1'b0 : overrun;
        case (state)
            IDLE: begin
                if (avg_done) begin
                    bin_next    = avg_new;
                    digits_next = '0;
                    step_next   = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                bin_next    = bin_sh;
                digits_next = digits_sh;
                step_next   = step + 4'd1;
                if (step == LAST_STEP) begin
                    bcd_out_next   = digits_sh;
                    bcd_valid_next = 1'b1;
                    // A fresh average on the completing edge is picked up without a gap.
                    if (avg_done) begin
                        bin_next    = avg_new;
                        digits_next = '0;
                        step_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (avg_done) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bin       <= '0;
            digits    <= '0;
            step      <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            bin       <= bin_next;
            digits    <= digits_next;
            step      <= step_next;
            bcd_out   <= bcd_out_next;
            bcd_valid <= bcd_valid_next;
            overrun   <= overrun_next;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Bench for adc_avg_bcd: directed scenarios plus random strobes, every cycle compared
// against a sample-queue / decimal-arithmetic reference model.
module tb_adc_avg_bcd;
    localparam int DATA_W = 12;
    localparam int LOG2N  = 3;
    localparam int N      = 1 << LOG2N;

    logic        SCLK = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [11:0] data_in = '0;
    logic        clear = 1'b0;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;
    int busy_cycles, avg_pulses, bcd_pulses;

    always #5 SCLK = ~SCLK;

    adc_avg_bcd #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
        .SCLK(SCLK), .reset(reset), .rx_done_tick(rx_done_tick), .data_in(data_in),
        .clear(clear), .avg_out(avg_out), .avg_valid(avg_valid), .bcd_out(bcd_out),
        .bcd_valid(bcd_valid), .busy(busy), .overrun(overrun)
    );

    // Reference model: pending samples, last average, and conversion countdown.
    int q[$];
    int m_avg, m_bcd, m_conv, m_busy_left;
    bit m_avg_v, m_bcd_v, m_ovr;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    task automatic model_reset();
        q.delete();
        m_avg = 0; m_bcd = 0; m_conv = 0; m_busy_left = 0;
        m_avg_v = 0; m_bcd_v = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit tick, input int d, input bit clr);
        bit newavg;
        int s;
        newavg = 0;
        m_avg_v = 0;
        m_bcd_v = 0;
        if (clr) begin
            q.delete();
            m_ovr = 0;
        end else if (tick) begin
            q.push_back(d);
            if (q.size() == N) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_avg = s / N;
                m_avg_v = 1;
                newavg = 1;
                q.delete();
            end
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_bcd = to_bcd(m_conv);
                m_bcd_v = 1;
                if (newavg) begin
                    m_conv = m_avg;
                    m_busy_left = 12;
                end
            end else if (newavg) begin
                m_ovr = 1;
            end
        end else if (newavg) begin
            m_conv = m_avg;
            m_busy_left = 12;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("avg_out",   32'(avg_out),   32'(m_avg));
        check("avg_valid", 32'(avg_valid), 32'(m_avg_v));
        check("bcd_out",   32'(bcd_out),   32'(m_bcd));
        check("bcd_valid", 32'(bcd_valid), 32'(m_bcd_v));
        check("busy",      32'(busy),      32'(m_busy_left > 0));
        check("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    task automatic step(input bit tick, input int d, input bit clr);
        @(negedge SCLK);
        rx_done_tick = tick;
        data_in = d[11:0];
        clear = clr;
        @(posedge SCLK);
        model_edge(tick, d, clr);
        #1;
        check_all();
        if (busy) busy_cycles++;
        if (avg_valid) avg_pulses++;
        if (bcd_valid) bcd_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic burst(input int n, input int d);
        for (int i = 0; i < n; i++) step(1, d, 0);
    endtask

    task automatic zero_counts();
        busy_cycles = 0; avg_pulses = 0; bcd_pulses = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge SCLK);
        check_all();
        reset = 1'b1;

        // 8 x 100
        zero_counts();
        burst(8, 100);
        idle(14);
        check("plan_avg100", 32'(avg_out), 32'd100);
        check("plan_bcd100", 32'(bcd_out), 32'h0100);
        check("plan_busy12", 32'(busy_cycles), 32'd12);
        check("plan_avg_pulses", 32'(avg_pulses), 32'd1);
        check("plan_bcd_pulses", 32'(bcd_pulses), 32'd1);

        // Full scale, no wrap
        burst(8, 4095);
        idle(14);
        check("plan_avg4095", 32'(avg_out), 32'd4095);
        check("plan_bcd4095", 32'(bcd_out), 32'h4095);

        // Truncation
        burst(7, 0);
        step(1, 7, 0);
        idle(14);
        check("plan_trunc0", 32'(avg_out), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 1000 + i, 0);
        idle(14);
        check("plan_avg1003", 32'(avg_out), 32'd1003);
        check("plan_bcd1003", 32'(bcd_out), 32'h1003);

        // Clear discards partial sets, including clear coincident with a strobe
        zero_counts();
        burst(5, 500);
        step(0, 0, 1);
        burst(4, 600);
        step(1, 600, 1);
        burst(3, 700);
        step(1, 700, 1);
        check("plan_clear_no_avg", 32'(avg_pulses), 32'd0);
        burst(8, 2048);
        idle(14);
        check("plan_avg2048", 32'(avg_out), 32'd2048);
        check("plan_bcd2048", 32'(bcd_out), 32'h2048);

        // Back-to-back: second average lands mid-conversion
        zero_counts();
        burst(8, 10);
        burst(8, 20);
        idle(16);
        check("plan_ovr_set", 32'(overrun), 32'd1);
        check("plan_ovr_avg20", 32'(avg_out), 32'd20);
        check("plan_ovr_bcd10", 32'(bcd_out), 32'h0010);
        check("plan_ovr_bcd_pulses", 32'(bcd_pulses), 32'd1);
        step(0, 0, 1);
        check("plan_ovr_cleared", 32'(overrun), 32'd0);

        // Reset mid-conversion at edge k+6
        burst(8, 300);
        idle(6);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge SCLK);
        reset = 1'b1;
        zero_counts();
        idle(16);
        check("plan_rst_no_bcd", 32'(bcd_pulses), 32'd0);
        burst(8, 777);
        idle(14);
        check("plan_post_rst_bcd", 32'(bcd_out), 32'h0777);

        // Random strobes, data and occasional clear
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                 bit'($urandom_range(0, 39) == 0));
        end
        idle(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
